// File: rtl/sysbus_mem_if_pkg.sv
// Shared types for the SysBus memory interface: FSM state encoding and wait-counter width.
package sysbus_types;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WDATA = 3'd1,
        READ  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } mem_state_t;

    localparam int WAIT_W = 4;

endpackage

// File: rtl/sysbus_mem_if_wait_counter.sv
// Loadable down-counter that saturates at zero; used for wait states and the optional timeout.
module wait_counter #(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/sysbus_mem_if.sv
// SysBus-to-memory bridge: captures address/data, runs a wait-stated MemReady handshake, returns read data.
// Optional abort on a stalled MemReady is enabled by defining SYSBUS_TIMEOUT_EN.
module sysbus_mem_if
    import sysbus_types::*;
#(
    parameter int WAIT_STATES = 2,
    parameter int TIMEOUT     = 64
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [15:0] SysBus,
    input  logic        ReqRead,
    input  logic        ReqWrite,
    output logic [15:0] RdData,
    output logic        Busy,
    output logic        Done,
    output logic        BusErr,
    output logic [15:0] MemAddr,
    output logic [15:0] MemWData,
    output logic        MemRd,
    output logic        MemWr,
    input  logic [15:0] MemRData,
    input  logic        MemReady,
    output mem_state_t  DbgState
);

    if (WAIT_STATES < 0 || WAIT_STATES > 15 || TIMEOUT < 1) begin : g_bad_params
        $error("sysbus_mem_if: WAIT_STATES must be 0..15 and TIMEOUT >= 1");
    end

    mem_state_t  state_q,    state_d;
    logic [15:0] rd_data_q,  rd_data_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic [15:0] mem_wdata_q, mem_wdata_d;
    logic        mem_rd_q,   mem_rd_d;
    logic        mem_wr_q,   mem_wr_d;
    logic        done_q,     done_d;

    logic wait_load;
    logic wait_dec;
    logic wait_zero;

    wait_counter #(
        .W (WAIT_W)
    ) u_wait_cnt (
        .clk_i      (Clock),
        .rst_i      (Reset),
        .load_i     (wait_load),
        .load_val_i (WAIT_W'(WAIT_STATES)),
        .dec_i      (wait_dec),
        .zero_o     (wait_zero)
    );

`ifdef SYSBUS_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic bus_err_q, bus_err_d;
    logic to_dec;
    logic to_zero;

    // Loaded alongside the wait counter; only counts once wait states are spent and MemReady is low.
    wait_counter #(
        .W (TO_W)
    ) u_timeout_cnt (
        .clk_i      (Clock),
        .rst_i      (Reset),
        .load_i     (wait_load),
        .load_val_i (TO_W'(TIMEOUT - 1)),
        .dec_i      (to_dec),
        .zero_o     (to_zero)
    );
`endif

    always_comb begin
        state_d     = state_q;
        rd_data_d   = rd_data_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        wait_load   = 1'b0;
        wait_dec    = 1'b0;
`ifdef SYSBUS_TIMEOUT_EN
        bus_err_d   = bus_err_q;
        to_dec      = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                // Read has priority when both strobes arrive together.
                if (ReqRead) begin
                    mem_addr_d = SysBus;
                    wait_load  = 1'b1;
                    state_d    = READ;
                end else if (ReqWrite) begin
                    mem_addr_d = SysBus;
                    state_d    = WDATA;
                end
            end
            WDATA: begin
                mem_wdata_d = SysBus;
                wait_load   = 1'b1;
                state_d     = WRITE;
            end
            READ, WRITE: begin
                if (!wait_zero) begin
                    wait_dec = 1'b1;
                end else if (MemReady) begin
                    if (state_q == READ) begin
                        rd_data_d = MemRData;
                    end
                    state_d = DONE;
`ifdef SYSBUS_TIMEOUT_EN
                end else if (to_zero) begin
                    bus_err_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    to_dec = 1'b1;
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Strobes and Done are registered from the next state so they align with it.
        mem_rd_d = (state_d == READ);
        mem_wr_d = (state_d == WRITE);
        done_d   = (state_d == DONE);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q     <= IDLE;
            rd_data_q   <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_data_q   <= rd_data_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            done_q      <= done_d;
        end
    end

`ifdef SYSBUS_TIMEOUT_EN
    always_ff @(posedge Clock) begin
        if (Reset) begin
            bus_err_q <= 1'b0;
        end else begin
            bus_err_q <= bus_err_d;
        end
    end

    assign BusErr = bus_err_q;
`else
    assign BusErr = 1'b0;
`endif

    assign RdData   = rd_data_q;
    assign MemAddr  = mem_addr_q;
    assign MemWData = mem_wdata_q;
    assign MemRd    = mem_rd_q;
    assign MemWr    = mem_wr_q;
    assign Done     = done_q;
    assign Busy     = (state_q != IDLE);
    assign DbgState = state_q;

endmodule

// File: doc/sysbus_mem_if.md
Name: sysbus_mem_if

Overview:
- Memory-side bus interface sitting directly downstream of the processor datapath's 16-bit SysBus.
- Captures an address (and, for writes, data) from SysBus under control-unit strobes.
- Runs an external memory read/write cycle with programmable minimum wait states and a MemReady handshake.
- Returns read data to the datapath DataIn input with a single-cycle Done pulse.

Parameters:
- WAIT_STATES, 2, minimum cycles MemRd/MemWr held before MemReady is sampled (0..15).
- TIMEOUT, 64, max cycles waiting for MemReady after wait states expire (used only with the optional feature).

Ports:
- Clock  input  1  system clock, all state on rising edge
- Reset  input  1  synchronous active-high reset
- SysBus  input  16  datapath system bus (address or write data)
- ReqRead  input  1  control strobe: SysBus holds read address this cycle
- ReqWrite  input  1  control strobe: SysBus holds write address this cycle
- RdData  output  16  read data to datapath DataIn
- Busy  output  1  high while not IDLE
- Done  output  1  one-cycle pulse at end of transfer
- BusErr  output  1  sticky timeout error (optional feature)
- MemAddr  output  16  external address
- MemWData  output  16  external write data
- MemRd  output  1  external read strobe
- MemWr  output  1  external write strobe
- MemRData  input  16  external read data
- MemReady  input  1  external completion handshake

Behaviour:
- Reset (synchronous, active-high): state IDLE. All outputs 0: RdData, MemAddr, MemWData, MemRd, MemWr, Done, BusErr. Wait counter 0.
- States: IDLE, WDATA, READ, WRITE, DONE.
- IDLE:
  - ReqRead: MemAddr<=SysBus, counter<=WAIT_STATES, go to READ.
  - ReqWrite: MemAddr<=SysBus, go to WDATA.
  - Both asserted: read wins; the write is dropped.
- WDATA: MemWData<=SysBus (control guarantees data on SysBus the cycle after ReqWrite), counter<=WAIT_STATES, go to WRITE.
- READ: MemRd=1.
  - Counter decrements each cycle while >0.
  - When counter==0 and MemReady=1: RdData<=MemRData, go to DONE.
  - MemReady is ignored while counter>0.
- WRITE: MemWr=1, MemAddr/MemWData stable; same counter/MemReady rule, then go to DONE.
- DONE: Done=1 for exactly one cycle, MemRd=MemWr=0, go to IDLE.
- MemRd and MemWr are registered, never both high, and deassert in DONE.
- Busy=1 in every state except IDLE. ReqRead/ReqWrite while Busy are ignored; no queueing.
- RdData holds its last read value until the next completed read. Writes do not change RdData.
- Latency, WAIT_STATES=0 and MemReady tied high:
  - read: ReqRead at cycle n, MemRd at n+1, Done and RdData valid at n+2.
  - write: Done at n+3.
- General read latency is 2+WAIT_STATES+(MemReady delay) cycles.
- Reset mid-transfer: strobes drop on the next edge, state returns to IDLE, no Done pulse.
- Wait counter is 4 bits and saturates at 0 (no wrap).

Optional Feature:
- Macro: SYSBUS_TIMEOUT_EN.
- Defined:
  - In READ/WRITE, after the wait counter reaches 0, a timeout counter counts cycles with MemReady=0.
  - Reaching TIMEOUT aborts the transfer: go to DONE, Done=1, BusErr<=1, RdData unchanged.
  - BusErr is cleared only by Reset.
- Undefined: waits indefinitely for MemReady; BusErr is tied 0 and the timeout counter is absent.

Decomposition:
- Shared package sysbus_types:
  - state enum typedef mem_state_t {IDLE, WDATA, READ, WRITE, DONE}.
  - constant width WAIT_W=4.
- Sub-module wait_counter: load value, decrement enable, zero flag, synchronous reset. Instantiated once for wait states and once more under SYSBUS_TIMEOUT_EN.

Test Plan:
- Read, WAIT_STATES=0: SysBus=16'h0040 with ReqRead, MemReady=1, MemRData=16'hBEEF.
  - Required: MemAddr=16'h0040 and MemRd at n+1; Done and RdData=16'hBEEF at n+2.
- Write, WAIT_STATES=2: ReqWrite with SysBus=16'h0100, then SysBus=16'h1234 next cycle, MemReady=1.
  - Required: MemWr high exactly 3 cycles with MemAddr=16'h0100, MemWData=16'h1234; Done one cycle later; RdData unchanged.
- Late ready: read with MemReady low for 5 cycles after wait states expire.
  - Required: MemRd held the whole time; RdData captured on the first MemReady=1 cycle; Busy=1 throughout.
- Simultaneous and busy requests: ReqRead and ReqWrite in the same cycle, then ReqWrite again while Busy.
  - Required: only a read is performed; MemWr never asserts; one Done pulse.
- Reset mid-read: Reset asserted during READ.
  - Required: next edge gives MemRd=0, Busy=0, RdData=0, Done=0.
- SYSBUS_TIMEOUT_EN, TIMEOUT=8: MemReady held low.
  - Required: Done pulse and BusErr=1 exactly 8 cycles after wait-state expiry.
  - BusErr stays 1 through a subsequent good read and clears only on Reset.
